// File: rtl/jtopl_eg_pkg.sv
// Shared constants and helpers for the OPL envelope-generator stepper:
// step patterns, rate clamp values and slot/counter width helpers.
package jtopl_eg_pkg;

  typedef logic [5:0] rate_t;
  typedef logic [7:0] pattern_t;

  // Patterns for rates 48..63 (rate[5:4]==3), indexed by rate[1:0]
  localparam pattern_t PAT_HI_0 = 8'h00;
  localparam pattern_t PAT_HI_1 = 8'h88;
  localparam pattern_t PAT_HI_2 = 8'hAA;
  localparam pattern_t PAT_HI_3 = 8'hEE;
  localparam pattern_t PAT_LO_0 = 8'hAA;
  localparam pattern_t PAT_LO_1 = 8'hEA;
  localparam pattern_t PAT_LO_2 = 8'hEE;
  localparam pattern_t PAT_LO_3 = 8'hFE;
  localparam pattern_t PAT_ALL  = 8'hFF;

  localparam logic [6:0] RATE_CLAMP_TH = 7'd60;
  localparam rate_t      RATE_MAX      = 6'd63;

  // Highest counter-select value that still picks a full 3-bit window
  function automatic int cnt_sel_max(input int cntw);
    return cntw - 3;
  endfunction

  function automatic int last_slot(input int slots);
    return slots - 1;
  endfunction

endpackage

// File: rtl/jtopl_eg_stepper_if.sv
// Per-slot input/output bundle of the envelope stepper.
interface jtopl_eg_stepper_if #(
  parameter int CNTW  = 15,
  parameter int SLOTW = 6
);
  logic             cen;
  logic             attack;
  logic [4:0]       base_rate;
  logic [3:0]       keycode;
  logic             ks;
  logic [SLOTW-1:0] slot;
  logic [CNTW-1:0]  eg_cnt;
  logic             step;
  logic [5:0]       rate;
  logic             sum_up;
  logic             sweep_end;

  modport master (
    output cen, attack, base_rate, keycode, ks,
    input  slot, eg_cnt, step, rate, sum_up, sweep_end
  );

  modport slave (
    input  cen, attack, base_rate, keycode, ks,
    output slot, eg_cnt, step, rate, sum_up, sweep_end
  );
endinterface

// File: rtl/jtopl_eg_rate.sv
// Combinational effective-rate, counter-window and step-pattern selection
// for the slot currently presented to the stepper.
module jtopl_eg_rate
  import jtopl_eg_pkg::*;
#(
  parameter int CNTW = 15
) (
  input  logic            i_attack,
  input  logic [4:0]      i_base_rate,
  input  logic [3:0]      i_keycode,
  input  logic            i_ks,
  input  logic [CNTW-1:0] i_eg_cnt,
  output rate_t           o_rate,
  output logic            o_step,
  output logic            o_cnt0
);

  localparam logic [4:0] SEL_MAX = 5'(cnt_sel_max(CNTW));

  logic [6:0] w_kc_add;
  logic [6:0] w_pre_rate;
  rate_t      w_rate;
  logic [4:0] w_sel;
  logic [2:0] w_cnt;
  pattern_t   w_pattern;
  logic       w_step;

  // Key-scaled rate, clamped to 63 at the top end
  always_comb begin
    w_kc_add = i_ks ? {3'b000, i_keycode} : {5'b00000, i_keycode[3:2]};
    if (i_base_rate == 5'd0) begin
      w_pre_rate = 7'd0;
    end else begin
      w_pre_rate = {1'b0, i_base_rate, 1'b0} + w_kc_add;
    end
    if (w_pre_rate >= RATE_CLAMP_TH) begin
      w_rate = RATE_MAX;
    end else begin
      w_rate = w_pre_rate[5:0];
    end
  end

  // Faster rates look at lower counter bits; attack runs one octave faster
  always_comb begin
    w_sel = i_attack ? ({1'b0, w_rate[5:2]} + 5'd1) : {1'b0, w_rate[5:2]};
    if (w_sel <= SEL_MAX) begin
      w_cnt = 3'(i_eg_cnt >> (SEL_MAX - w_sel));
    end else begin
      w_cnt = i_eg_cnt[2:0];
    end
  end

  // Step pattern lookup
  always_comb begin
    w_pattern = PAT_LO_0;
    if (w_rate[5:4] == 2'b11) begin
      if ((w_rate[5:2] == 4'd15) && i_attack) begin
        w_pattern = PAT_ALL;
      end else begin
        case (w_rate[1:0])
          2'd0:    w_pattern = PAT_HI_0;
          2'd1:    w_pattern = PAT_HI_1;
          2'd2:    w_pattern = PAT_HI_2;
          2'd3:    w_pattern = PAT_HI_3;
          default: w_pattern = PAT_HI_0;
        endcase
      end
    end else begin
      if ((w_rate[5:2] == 4'd0) && !i_attack) begin
        w_pattern = PAT_LO_3;
      end else begin
        case (w_rate[1:0])
          2'd0:    w_pattern = PAT_LO_0;
          2'd1:    w_pattern = PAT_LO_1;
          2'd2:    w_pattern = PAT_LO_2;
          2'd3:    w_pattern = PAT_LO_3;
          default: w_pattern = PAT_LO_0;
        endcase
      end
    end
  end

  // Rates 0 and 1 never step
  always_comb begin
    if (w_rate[5:1] == 5'd0) begin
      w_step = 1'b0;
    end else begin
      w_step = w_pattern[w_cnt];
    end
  end

  assign o_rate = w_rate;
  assign o_step = w_step;
  assign o_cnt0 = w_cnt[0];

endmodule

// File: rtl/jtopl_eg_stepper.sv
// Time-multiplexed envelope stepper: slot/envelope counters, per-slot phase
// store and the registered one-cen-latency result stage.
module jtopl_eg_stepper
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15,
  parameter int SLOTW = 6
) (
  input logic               clk,
  input logic               rst_n,
  jtopl_eg_stepper_if.slave bus
);

  localparam logic [SLOTW-1:0] LAST_SLOT     = SLOTW'(last_slot(SLOTS));
  localparam logic             SWEEP_END_RST = (SLOTS == 1) ? 1'b1 : 1'b0;

  logic [SLOTW-1:0] r_in_slot;
  logic [CNTW-1:0]  r_eg_cnt;
  logic [SLOTS-1:0] r_store;
  logic [SLOTW-1:0] r_slot;
  rate_t            r_rate;
  logic             r_step;
  logic             r_sum_up;
  logic             r_sweep_end;

  rate_t w_rate;
  logic  w_step;
  logic  w_cnt0;
  logic  w_last;
  logic  w_stored;

  jtopl_eg_rate #(.CNTW(CNTW)) u_rate (
    .i_attack    (bus.attack),
    .i_base_rate (bus.base_rate),
    .i_keycode   (bus.keycode),
    .i_ks        (bus.ks),
    .i_eg_cnt    (r_eg_cnt),
    .o_rate      (w_rate),
    .o_step      (w_step),
    .o_cnt0      (w_cnt0)
  );

  assign w_last = (r_in_slot == LAST_SLOT);

  // Read this slot's phase bit from the previous sweep
  always_comb begin
    w_stored = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      w_stored = w_stored | (r_store[i] & (r_in_slot == SLOTW'(i)));
    end
  end

  // Input slot counter and global envelope counter (bumped once per sweep)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_slot <= '0;
      r_eg_cnt  <= '0;
    end else if (bus.cen) begin
      if (w_last) begin
        r_in_slot <= '0;
        r_eg_cnt  <= r_eg_cnt + CNTW'(1'b1);
      end else begin
        r_in_slot <= r_in_slot + SLOTW'(1'b1);
      end
    end
  end

  // Per-slot phase store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store <= '0;
    end else if (bus.cen) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (r_in_slot == SLOTW'(i)) begin
          r_store[i] <= w_cnt0;
        end
      end
    end
  end

  // Output stage, tagged with the slot the inputs belonged to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_rate      <= '0;
      r_step      <= 1'b0;
      r_sum_up    <= 1'b0;
      r_sweep_end <= SWEEP_END_RST;
    end else if (bus.cen) begin
      r_slot      <= r_in_slot;
      r_rate      <= w_rate;
      r_step      <= w_step;
      r_sum_up    <= w_cnt0 ^ w_stored;
      r_sweep_end <= w_last;
    end
  end

  assign bus.slot      = r_slot;
  assign bus.eg_cnt    = r_eg_cnt;
  assign bus.step      = r_step;
  assign bus.rate      = r_rate;
  assign bus.sum_up    = r_sum_up;
  assign bus.sweep_end = r_sweep_end;

endmodule

// File: tb/tb_jtopl_eg_stepper.sv
// Directed bench: an 18-slot instance for rate/step/phase/reset behaviour and
// a 2-slot instance for the full envelope-counter wrap.
module tb_jtopl_eg_stepper;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   incr   = 0;
  int   bad    = 0;
  logic [14:0] prev_eg;

  always #5 clk = ~clk;

  jtopl_eg_stepper_if #(.CNTW(15), .SLOTW(6)) if1 ();
  jtopl_eg_stepper_if #(.CNTW(15), .SLOTW(1)) if2 ();

  jtopl_eg_stepper #(.SLOTS(18), .CNTW(15), .SLOTW(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  jtopl_eg_stepper #(.SLOTS(2), .CNTW(15), .SLOTW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input int br, input int kc, input int ks, input int att);
    if1.base_rate = 5'(br);
    if1.keycode   = 4'(kc);
    if1.ks        = 1'(ks);
    if1.attack    = 1'(att);
  endtask

  task automatic set2(input int br, input int kc, input int ks, input int att);
    if2.base_rate = 5'(br);
    if2.keycode   = 4'(kc);
    if2.ks        = 1'(ks);
    if2.attack    = 1'(att);
  endtask

  initial begin
    rst_n   = 1'b0;
    if1.cen = 1'b0;
    if2.cen = 1'b0;
    set1(0, 0, 0, 0);
    set2(0, 0, 0, 0);
    #12;
    check("rst_slot", 32'(if1.slot), 32'd0);
    check("rst_eg", 32'(if1.eg_cnt), 32'd0);
    check("rst_rate", 32'(if1.rate), 32'd0);
    check("rst_step", 32'(if1.step), 32'd0);
    check("rst_sum_up", 32'(if1.sum_up), 32'd0);
    check("rst_sweep_end", 32'(if1.sweep_end), 32'd0);
    rst_n = 1'b1;

    // rate 45 at eg_cnt=0: window eg_cnt[3:1]=0 -> EA bit0 = 0
    if1.cen = 1'b1;
    set1(15, 15, 1, 0);
    tick();
    check("e1_slot", 32'(if1.slot), 32'd0);
    check("e1_rate", 32'(if1.rate), 32'd45);
    check("e1_step", 32'(if1.step), 32'd0);
    check("e1_sum_up", 32'(if1.sum_up), 32'd0);

    // base_rate 0 never steps regardless of keycode/ks/attack
    for (int k = 2; k <= 36; k++) begin
      set1(0, k % 16, (k / 2) % 2, k % 2);
      tick();
      check("br0_rate", 32'(if1.rate), 32'd0);
      check("br0_step", 32'(if1.step), 32'd0);
      check("br0_slot", 32'(if1.slot), 32'((k - 1) % 18));
      check("br0_sweep_end", 32'(if1.sweep_end), 32'(((k - 1) % 18) == 17));
    end
    check("eg_after_2_sweeps", 32'(if1.eg_cnt), 32'd2);

    // rate 45 at eg_cnt=2: window eg_cnt[3:1]=1 -> EA bit1 = 1
    set1(15, 15, 1, 0);
    tick();
    check("e37_slot", 32'(if1.slot), 32'd0);
    check("e37_rate", 32'(if1.rate), 32'd45);
    check("e37_step", 32'(if1.step), 32'd1);

    // rate 63 attack: pattern FF over eg_cnt 2..10 (all 8 windows)
    for (int k = 38; k <= 198; k++) begin
      set1(31, 15, 1, 1);
      tick();
      check("r63_rate", 32'(if1.rate), 32'd63);
      check("r63_step", 32'(if1.step), 32'd1);
      check("r63_sweep_end", 32'(if1.sweep_end), 32'(((k - 1) % 18) == 17));
    end

    // eg_cnt 10 -> 11: slot 0 (watches bit 0) flips, slot 1 (bit 12) does not
    set1(31, 15, 1, 1);
    tick();
    check("ph_slot0", 32'(if1.slot), 32'd0);
    check("ph_eg", 32'(if1.eg_cnt), 32'd11);
    check("ph_sum_up0", 32'(if1.sum_up), 32'd1);
    set1(1, 0, 0, 0);
    tick();
    check("ph_slot1", 32'(if1.slot), 32'd1);
    check("ph_rate1", 32'(if1.rate), 32'd2);
    check("ph_step1", 32'(if1.step), 32'd0);
    check("ph_sum_up1", 32'(if1.sum_up), 32'd0);

    // cen low: everything holds
    if1.cen = 1'b0;
    set1(31, 15, 1, 1);
    tick();
    tick();
    tick();
    check("hold_slot", 32'(if1.slot), 32'd1);
    check("hold_rate", 32'(if1.rate), 32'd2);
    check("hold_eg", 32'(if1.eg_cnt), 32'd11);

    // advance to slot 7, then reset asynchronously
    if1.cen = 1'b1;
    set1(15, 15, 1, 0);
    tick();
    check("resume_slot", 32'(if1.slot), 32'd2);
    for (int k = 0; k < 5; k++) tick();
    check("s7_slot", 32'(if1.slot), 32'd7);
    check("s7_rate", 32'(if1.rate), 32'd45);
    check("s7_step", 32'(if1.step), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_slot", 32'(if1.slot), 32'd0);
    check("arst_rate", 32'(if1.rate), 32'd0);
    check("arst_step", 32'(if1.step), 32'd0);
    check("arst_eg", 32'(if1.eg_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_slot", 32'(if1.slot), 32'd0);
    check("post_rst_rate", 32'(if1.rate), 32'd45);
    check("post_rst_eg", 32'(if1.eg_cnt), 32'd0);
    check("post_rst_sum_up", 32'(if1.sum_up), 32'd0);
    if1.cen = 1'b0;

    // 2-slot instance: full eg_cnt wrap, slot 0 phase watches eg_cnt[12]
    prev_eg = 15'd0;
    if2.cen = 1'b1;
    for (int k = 1; k <= 65536; k++) begin
      if (k % 2 == 1) set2(1, 0, 0, 0);
      else            set2(31, 15, 1, 0);
      tick();
      if (if2.eg_cnt !== prev_eg) begin
        incr++;
        if (!(if2.sweep_end === 1'b1 && if2.eg_cnt === 15'(prev_eg + 15'd1))) bad++;
      end else if (if2.sweep_end === 1'b1) begin
        bad++;
      end
      prev_eg = if2.eg_cnt;
      case (k)
        8191: check("w_sum_up_4095", 32'(if2.sum_up), 32'd0);
        8193: begin
          check("w_sum_up_4096", 32'(if2.sum_up), 32'd1);
          check("w_eg_4096", 32'(if2.eg_cnt), 32'd4096);
          check("w_step_4096", 32'(if2.step), 32'd1);
        end
        8194: begin
          check("w_rate_s1", 32'(if2.rate), 32'd63);
          check("w_step_s1_c0", 32'(if2.step), 32'd0);
        end
        8195: check("w_sum_up_4097", 32'(if2.sum_up), 32'd0);
        8196: check("w_step_s1_c1", 32'(if2.step), 32'd1);
        65535: begin
          check("w_eg_max", 32'(if2.eg_cnt), 32'd32767);
          check("w_sweep_end_s0", 32'(if2.sweep_end), 32'd0);
        end
        65536: begin
          check("w_eg_wrap", 32'(if2.eg_cnt), 32'd0);
          check("w_sweep_end_s1", 32'(if2.sweep_end), 32'd1);
          check("w_slot_s1", 32'(if2.slot), 32'd1);
        end
        default: ;
      endcase
    end
    check("w_incr_count", 32'(incr), 32'd32768);
    check("w_incr_bad", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtopl_eg_stepper.md
JTOPL_EG_STEPPER -- requirements
Module: jtopl_eg_stepper

Interface
REQ-001 Parameter SLOTS, default 18: number of operator slots time-multiplexed per sweep (2..36).
REQ-002 Parameter CNTW, default 15: width of the global envelope counter (15..18).
REQ-003 Parameter SLOTW, default 6: width of the slot index, with 2^SLOTW >= SLOTS.
REQ-004 clk  in  1  single clock for the whole block.
REQ-005 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 cen  in  1  clock enable; state advances only on clk edges with cen=1.
REQ-007 attack  in  1  current slot is in attack phase.
REQ-008 base_rate  in  5  current slot base rate.
REQ-009 keycode  in  4  current slot keycode.
REQ-010 ks  in  1  key-scale select: 1 adds the full keycode, 0 adds keycode[3:2].
REQ-011 slot  out  SLOTW  index of the slot whose results are on the outputs.
REQ-012 eg_cnt  out  CNTW  global envelope counter.
REQ-013 step  out  1  apply an envelope step to this slot.
REQ-014 rate  out  6  effective rate.
REQ-015 sum_up  out  1  counter phase changed since this slot's previous sweep.
REQ-016 sweep_end  out  1  high while slot==SLOTS-1.

Function
REQ-017 An internal input slot counter SHALL advance by 1 per cen, wrapping from SLOTS-1 to 0; inputs belong to that slot.
REQ-018 eg_cnt SHALL increment by 1 on the cen on which the input slot counter wraps, and wrap from 2^CNTW-1 to 0.
REQ-019 pre_rate (7 bits) SHALL be 0 if base_rate==0, else 2*base_rate + (ks ? keycode : keycode[3:2]).
REQ-020 rate SHALL be 63 if pre_rate>=60, else pre_rate[5:0].
REQ-021 sel SHALL be rate[5:2]+1 when attack, else rate[5:2] (5 bits); cnt[2:0] SHALL be eg_cnt[CNTW-1-sel -: 3] for sel<=CNTW-3, else eg_cnt[2:0].
REQ-022 If rate[5:4]==3: the pattern SHALL be 8'hFF when rate[5:2]==15 and attack; otherwise 00, 88, AA, EE (hex) for rate[1:0]=0..3.
REQ-023 If rate[5:4]!=3: the pattern SHALL be FE when rate[5:2]==0 and !attack; otherwise AA, EA, EE, FE for rate[1:0]=0..3.
REQ-024 step SHALL be 0 when rate[5:1]==0, else pattern bit[cnt].
REQ-025 A SLOTS-deep circular store SHALL hold each slot's cnt[0] from its last evaluation; sum_up SHALL be cnt[0] XOR the stored bit, and the store SHALL then take cnt[0].
REQ-026 Latency SHALL be exactly one cen: inputs sampled on cen N appear on slot/rate/step/sum_up after edge N, tagged by slot.
REQ-027 The cnt evaluation SHALL use the eg_cnt value before any same-edge increment.
REQ-028 With cen=0, all outputs and state SHALL hold.

Reset
REQ-029 With rst_n low: slot, eg_cnt, rate, step, sum_up, the input slot counter and every store bit SHALL be 0, and sweep_end SHALL be 0 unless SLOTS-1==0.
REQ-030 After rst_n rises, the first input sampled SHALL belong to slot 0.
REQ-031 Reset asserted mid-sweep SHALL discard all state immediately, without waiting for clk.

Structure
REQ-032 Step patterns (8 constants), the rate clamp value 60/63 and the slot/counter width helpers SHALL live in package jtopl_eg_pkg.
REQ-033 Combinational rate/cnt/pattern selection SHALL be a sub-module jtopl_eg_rate; jtopl_eg_stepper SHALL own the counters, store and output registers.

Verification
REQ-034 base_rate=0, any keycode/ks/attack -> rate=0, step=0 for every eg_cnt.
REQ-035 base_rate=15, ks=1, keycode=15, attack=0, eg_cnt=2 -> rate=45, cnt=eg_cnt[3:1]=1, step=1; at eg_cnt=0, step=0.
REQ-036 base_rate=31, ks=1, keycode=15 -> rate=63; with attack=1, step=1 for all 8 cnt values.
REQ-037 SLOTS=18, cen held high for 18*2^15 cycles -> eg_cnt returns to 0, with exactly one increment per sweep, coincident with sweep_end.
REQ-038 One slot with base_rate=1, attack=0, driven for two sweeps where eg_cnt[12] differs -> sum_up=1 on the second sweep; other slots unaffected.
REQ-039 rst_n pulsed low mid-sweep (slot 7) -> all outputs 0 asynchronously; next sampled input tagged slot 0.
